ntt_addr_map: RTL and testbench

Conflict-free memory address mapper for the radix-16 NWC NTT datapath. It sits directly downstream of the address generation unit. Each cycle it takes the 16 coefficient indices of one radix-16 butterfly group and converts them into a per-bank address plus a lane-select vector for 16 single-port coefficient banks. It issues the read set first, then the matching write-back set after a fixed PE latency, and signals when a transform's last write has been issued.

---
 rtl/ntt_addr_map.sv | 217 +++++++++++++++++++++
 tb/tb_ntt_addr_map.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_addr_map.sv
// ntt_addr_map -- conflict-free bank mapper for the radix-16 NWC NTT datapath.
//
// Takes the LANES coefficient indices of one butterfly group per cycle and
// routes them onto LANES single-port banks. The bank of index x is the sum of
// its LOG_L-bit digits modulo LANES; the in-bank address is x >> LOG_L.
// The read set is issued two cycles after the group is accepted, and the
// identical write-back set PE_LAT cycles after that.
//
// Handshake: valid-only streaming, no backpressure. in_en qualifies ord_in/in_l
// in the cycle it is high; rd_en and wr_en qualify their buses in the cycle
// they are high. Buses are don't-care (they hold) while their valid is low.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   in_en        ord_in/in_l valid this cycle
//   in_done      one-cycle pulse: AGU finished the transform
//   in_l         stage number of the incoming group
//   ord_in       lane k index at [k*D_WIDTH +: D_WIDTH]
//   rd_en        read set valid
//   rd_addr      bank b address at [b*AW +: AW]
//   rd_sel       lane feeding bank b at [b*LOG_L +: LOG_L]
//   rd_l         stage of the read set
//   wr_en        write-back set valid
//   wr_addr      rd_addr delayed by PE_LAT cycles
//   wr_sel       rd_sel delayed by PE_LAT cycles
//   map_done     one-cycle pulse after the transform's last write-back
//   err_conflict sticky bank-conflict flag
module ntt_addr_map #(
  parameter int D_WIDTH = 12,
  parameter int LANES   = 16,
  parameter int LOG_L   = 4,
  parameter int AW      = 8,
  parameter int PE_LAT  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_en,
  input  logic                     in_done,
  input  logic [2:0]               in_l,
  input  logic [LANES*D_WIDTH-1:0] ord_in,
  output logic                     rd_en,
  output logic [LANES*AW-1:0]      rd_addr,
  output logic [LANES*LOG_L-1:0]   rd_sel,
  output logic [2:0]               rd_l,
  output logic                     wr_en,
  output logic [LANES*AW-1:0]      wr_addr,
  output logic [LANES*LOG_L-1:0]   wr_sel,
  output logic                     map_done,
  output logic                     err_conflict
);

  localparam int NDIG = D_WIDTH / LOG_L;

  // Digit sum; the adder width discards carries, giving mod 2^LOG_L.
  function automatic logic [LOG_L-1:0] bank_of(input logic [D_WIDTH-1:0] x);
    logic [LOG_L-1:0] s;
    s = '0;
    for (int d = 0; d < NDIG; d++) begin
      s = s + x[d*LOG_L +: LOG_L];
    end
    return s;
  endfunction

  // ---------------------------------------------------------------- S1
  logic                     s1_v_q;
  logic [2:0]               s1_l_q;
  logic [LANES*LOG_L-1:0]   s1_bank_q, s1_bank_d;
  logic [LANES*AW-1:0]      s1_addr_q, s1_addr_d;

  always_comb begin
    s1_bank_d = '0;
    s1_addr_d = '0;
    for (int k = 0; k < LANES; k++) begin
      s1_bank_d[k*LOG_L +: LOG_L] = bank_of(ord_in[k*D_WIDTH +: D_WIDTH]);
      s1_addr_d[k*AW +: AW]       = ord_in[k*D_WIDTH + LOG_L +: AW];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v_q    <= 1'b0;
      s1_l_q    <= '0;
      s1_bank_q <= '0;
      s1_addr_q <= '0;
    end else begin
      s1_v_q <= in_en;
      if (in_en) begin
        s1_l_q    <= in_l;
        s1_bank_q <= s1_bank_d;
        s1_addr_q <= s1_addr_d;
      end
    end
  end

  // ---------------------------------------------------------------- S2 crossbar
  // For every bank, the lowest-numbered lane that targets it wins. A bank
  // hit by zero lanes or by more than one lane flags a conflict.
  logic [LANES*AW-1:0]    xb_addr_d;
  logic [LANES*LOG_L-1:0] xb_sel_d;
  logic                   xb_conflict;
  logic                   found;

  always_comb begin
    xb_addr_d   = '0;
    xb_sel_d    = '0;
    xb_conflict = 1'b0;
    found       = 1'b0;
    for (int b = 0; b < LANES; b++) begin
      found = 1'b0;
      for (int k = 0; k < LANES; k++) begin
        if (s1_bank_q[k*LOG_L +: LOG_L] == LOG_L'(b)) begin
          if (!found) begin
            xb_addr_d[b*AW +: AW]     = s1_addr_q[k*AW +: AW];
            xb_sel_d[b*LOG_L +: LOG_L] = LOG_L'(k);
            found = 1'b1;
          end else begin
            xb_conflict = 1'b1;
          end
        end
      end
      if (!found) begin
        xb_conflict = 1'b1;
      end
    end
  end

  logic                   rd_en_q;
  logic [LANES*AW-1:0]    rd_addr_q;
  logic [LANES*LOG_L-1:0] rd_sel_q;
  logic [2:0]             rd_l_q;
  logic                   err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_sel_q  <= '0;
      rd_l_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      rd_en_q <= s1_v_q;
      // Registered alongside rd_en so the flag rises with the offending set.
      err_q   <= err_q | (s1_v_q & xb_conflict);
      if (s1_v_q) begin
        rd_addr_q <= xb_addr_d;
        rd_sel_q  <= xb_sel_d;
        rd_l_q    <= s1_l_q;
      end
    end
  end

  // ---------------------------------------------------------------- delay line
  // Free-running shift register; bubbles travel through as invalid slots.
  logic                   dly_v_q    [PE_LAT];
  logic [LANES*AW-1:0]    dly_addr_q [PE_LAT];
  logic [LANES*LOG_L-1:0] dly_sel_q  [PE_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PE_LAT; i++) begin
        dly_v_q[i]    <= 1'b0;
        dly_addr_q[i] <= '0;
        dly_sel_q[i]  <= '0;
      end
    end else begin
      dly_v_q[0]    <= rd_en_q;
      dly_addr_q[0] <= rd_addr_q;
      dly_sel_q[0]  <= rd_sel_q;
      for (int i = 1; i < PE_LAT; i++) begin
        dly_v_q[i]    <= dly_v_q[i-1];
        dly_addr_q[i] <= dly_addr_q[i-1];
        dly_sel_q[i]  <= dly_sel_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------- done tracking
  logic pend_q, pend_d;
  logic any_dly;
  logic idle;

  always_comb begin
    any_dly = 1'b0;
    for (int i = 0; i < PE_LAT; i++) begin
      any_dly = any_dly | dly_v_q[i];
    end
  end

  // The last delay slot is wr_en, so any_dly also covers "wr_en = 0".
  assign idle = ~s1_v_q & ~rd_en_q & ~any_dly;

  // A fresh in_done in the idle cycle defers the pulse to the next idle cycle,
  // and an in_done while pending simply keeps pend set (pulses merge).
  always_comb begin
    map_done = pend_q & idle & ~in_done;
    pend_d   = in_done | (pend_q & ~map_done);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign rd_en        = rd_en_q;
  assign rd_addr      = rd_addr_q;
  assign rd_sel       = rd_sel_q;
  assign rd_l         = rd_l_q;
  assign wr_en        = dly_v_q[PE_LAT-1];
  assign wr_addr      = dly_addr_q[PE_LAT-1];
  assign wr_sel       = dly_sel_q[PE_LAT-1];
  assign err_conflict = err_q;

endmodule

// File: tb/tb_ntt_addr_map.sv
// Self-checking bench for ntt_addr_map: expected read/write sets are queued
// when a group is driven; a negedge monitor pops and compares them.
module tb_ntt_addr_map;

  localparam int D_WIDTH = 12;
  localparam int LANES   = 16;
  localparam int LOG_L   = 4;
  localparam int AW      = 8;
  localparam int PE_LAT  = 8;
  localparam int RD_W    = 1 + 3 + LANES*AW + LANES*LOG_L;
  localparam int WR_W    = LANES*AW + LANES*LOG_L;
  localparam int ALL_W   = 1 + LANES*AW + LANES*LOG_L + 3 + 1 + LANES*AW + LANES*LOG_L + 1 + 1;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                     in_en   = 1'b0;
  logic                     in_done = 1'b0;
  logic [2:0]               in_l    = '0;
  logic [LANES*D_WIDTH-1:0] ord_in  = '0;
  logic                     rd_en, wr_en, map_done, err_conflict;
  logic [LANES*AW-1:0]      rd_addr, wr_addr;
  logic [LANES*LOG_L-1:0]   rd_sel, wr_sel;
  logic [2:0]               rd_l;

  ntt_addr_map #(
    .D_WIDTH(D_WIDTH), .LANES(LANES), .LOG_L(LOG_L), .AW(AW), .PE_LAT(PE_LAT)
  ) dut (
    .clk(clk), .rst(rst), .in_en(in_en), .in_done(in_done), .in_l(in_l),
    .ord_in(ord_in), .rd_en(rd_en), .rd_addr(rd_addr), .rd_sel(rd_sel),
    .rd_l(rd_l), .wr_en(wr_en), .wr_addr(wr_addr), .wr_sel(wr_sel),
    .map_done(map_done), .err_conflict(err_conflict)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [RD_W-1:0] exp_rd_q[$];
  int              exp_rd_cyc[$];
  logic [WR_W-1:0] exp_wr_q[$];
  int              exp_wr_cyc[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   rd_seen = 0;
  int   wr_seen = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  int   last_wr_cyc = -1;
  logic err_model = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [RD_W-1:0] ri;
    logic [WR_W-1:0] wi;
    int              c;
    if (rst) begin
      if (rd_en) begin
        rd_seen++;
        if (exp_rd_q.size() == 0) begin
          check("rd_unexpected", 512'(rd_en), 512'(0));
        end else begin
          ri = exp_rd_q.pop_front();
          c  = exp_rd_cyc.pop_front();
          check("rd_cycle", 512'(cyc), 512'(c));
          check("rd_l", 512'(rd_l), 512'(ri[RD_W-2 -: 3]));
          check("rd_addr", 512'(rd_addr), 512'(ri[WR_W-1 -: LANES*AW]));
          check("rd_sel", 512'(rd_sel), 512'(ri[LANES*LOG_L-1:0]));
          if (ri[RD_W-1]) err_model = 1'b1;
          check("err_conflict", 512'(err_conflict), 512'(err_model));
        end
      end
      if (wr_en) begin
        wr_seen++;
        last_wr_cyc = cyc;
        if (exp_wr_q.size() == 0) begin
          check("wr_unexpected", 512'(wr_en), 512'(0));
        end else begin
          wi = exp_wr_q.pop_front();
          c  = exp_wr_cyc.pop_front();
          check("wr_cycle", 512'(cyc), 512'(c));
          check("wr_addr", 512'(wr_addr), 512'(wi[WR_W-1 -: LANES*AW]));
          check("wr_sel", 512'(wr_sel), 512'(wi[LANES*LOG_L-1:0]));
        end
      end
      if (map_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic send(input logic [LANES*D_WIDTH-1:0] ord, input logic [2:0] l,
                      input logic [LANES*AW-1:0] ea, input logic [LANES*LOG_L-1:0] es,
                      input logic conf);
    @(posedge clk); #1;
    ord_in = ord;
    in_l   = l;
    in_en  = 1'b1;
    exp_rd_q.push_back({conf, l, ea, es});
    exp_rd_cyc.push_back(cyc + 2);
    exp_wr_q.push_back({ea, es});
    exp_wr_cyc.push_back(cyc + 2 + PE_LAT);
    @(posedge clk); #1;
    in_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    @(posedge clk); #1;
    in_done = 1'b1;
    @(posedge clk); #1;
    in_done = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    @(negedge clk);
    check(name, 512'({rd_en, rd_addr, rd_sel, rd_l, wr_en, wr_addr, wr_sel,
                      map_done, err_conflict}), 512'(0));
  endtask

  // Reference mapping for the stream: bank = (d0+d1+d2) mod 16, addr = x/16.
  task automatic model(input logic [LANES*D_WIDTH-1:0] ord,
                       output logic [LANES*AW-1:0] ea, output logic [LANES*LOG_L-1:0] es);
    int x, bk;
    ea = '0;
    es = '0;
    for (int k = 0; k < LANES; k++) begin
      x  = int'(ord[k*D_WIDTH +: D_WIDTH]);
      bk = ((x % 16) + ((x / 16) % 16) + (x / 256)) % 16;
      ea[bk*AW +: AW]       = AW'(x / 16);
      es[bk*LOG_L +: LOG_L] = LOG_L'(k);
    end
  endtask

  // AGU group order: stage s varies digit 2-s across the lanes.
  function automatic logic [LANES*D_WIDTH-1:0] gen_group(input int s, input int i);
    logic [LANES*D_WIDTH-1:0] g;
    int x;
    g = '0;
    for (int k = 0; k < LANES; k++) begin
      if (s == 0)      x = k*256 + i;
      else if (s == 1) x = (i/16)*256 + k*16 + (i%16);
      else             x = i*16 + k;
      g[k*D_WIDTH +: D_WIDTH] = D_WIDTH'(x);
    end
    return g;
  endfunction

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [LANES*D_WIDTH-1:0] ord;
    logic [LANES*AW-1:0]      ea;
    logic [LANES*LOG_L-1:0]   es;
    int rd0, wr0, d0, wait_cnt;

    // Reset and idle
    for (int i = 0; i < 3; i++) check_all_zero("reset_outputs");
    #1 rst = 1'b1;
    for (int i = 0; i < 20; i++) check_all_zero("idle_outputs");

    // Stage 0, i=0: lane k = k*256 -> bank k, addr k*16
    for (int k = 0; k < LANES; k++) begin
      ord[k*D_WIDTH +: D_WIDTH] = D_WIDTH'(k*256);
      ea[k*AW +: AW]            = AW'(k*16);
      es[k*LOG_L +: LOG_L]      = LOG_L'(k);
    end
    send(ord, 3'd0, ea, es, 1'b0);
    idle(14);

    // Stage 1, i=5: lane k = k*16+5 -> bank b gets lane (b+11) mod 16, addr same
    for (int k = 0; k < LANES; k++) begin
      ord[k*D_WIDTH +: D_WIDTH] = D_WIDTH'(k*16 + 5);
      ea[k*AW +: AW]            = AW'((k + 11) % 16);
      es[k*LOG_L +: LOG_L]      = LOG_L'((k + 11) % 16);
    end
    send(ord, 3'd1, ea, es, 1'b0);
    idle(14);
    check("no_done_before_stream", 512'(done_cnt), 512'(0));

    // Full stream with gaps
    rd0 = rd_seen;
    wr0 = wr_seen;
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 256; i++) begin
        ord = gen_group(s, i);
        model(ord, ea, es);
        send(ord, 3'(s), ea, es, 1'b0);
        idle($urandom_range(1, 3) - 1);
      end
    end
    pulse_done();
    wait_cnt = 0;
    while (done_cnt == 0 && wait_cnt < 300) begin
      @(posedge clk);
      wait_cnt++;
    end
    idle(20);
    check("map_done_count", 512'(done_cnt), 512'(1));
    check("map_done_timing", 512'(done_cyc), 512'(last_wr_cyc + 1));
    check("stream_rd_count", 512'(rd_seen - rd0), 512'(768));
    check("stream_wr_count", 512'(wr_seen - wr0), 512'(768));
    check("rd_queue_drained", 512'(exp_rd_q.size()), 512'(0));
    check("wr_queue_drained", 512'(exp_wr_q.size()), 512'(0));
    check("err_after_stream", 512'(err_conflict), 512'(0));

    // Conflict: lanes 0 and 1 both hit bank 1, bank 0 is empty
    ord = '0;
    ea  = '0;
    es  = '0;
    ord[0*D_WIDTH +: D_WIDTH] = D_WIDTH'(1);
    ord[1*D_WIDTH +: D_WIDTH] = D_WIDTH'(16);
    for (int k = 2; k < LANES; k++) begin
      ord[k*D_WIDTH +: D_WIDTH] = D_WIDTH'(k);
      es[k*LOG_L +: LOG_L]      = LOG_L'(k);
    end
    send(ord, 3'd2, ea, es, 1'b1);
    idle(14);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("err_sticky", 512'(err_conflict), 512'(1));
    end

    // Reset mid-stream with groups in flight and pend set
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) begin
      ord = gen_group(0, i);
      model(ord, ea, es);
      send(ord, 3'd0, ea, es, 1'b0);
    end
    pulse_done();
    rst = 1'b0;
    exp_rd_q.delete();
    exp_rd_cyc.delete();
    exp_wr_q.delete();
    exp_wr_cyc.delete();
    err_model = 1'b0;
    for (int i = 0; i < 3; i++) check_all_zero("mid_reset_outputs");
    #1 rst = 1'b1;
    for (int i = 0; i < 30; i++) check_all_zero("post_reset_outputs");
    check("no_done_after_reset", 512'(done_cnt), 512'(d0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
